// File: rtl/s27_bist_pkg.sv
// Shared types and constants for the s27 BIST controller:
// FSM state encoding, LFSR/SISR polynomials and datapath widths.
package s27_bist_pkg;

    localparam int unsigned LFSR_W = 4;
    localparam int unsigned SIG_W  = 8;
    localparam int unsigned CNT_W  = 8;

    // x^4+x^3+1: feedback is lfsr[3]^lfsr[2]
    localparam logic [LFSR_W-1:0] LFSR_TAPS = 4'b1100;
    // x^8+x^4+x^3+x^2+1 with the x^8 term implied by the shift-out bit
    localparam logic [SIG_W-1:0]  SISR_POLY = 8'h1D;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WARM = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] v);
        return {v[LFSR_W-2:0], ^(v & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/bist_sisr.sv
// Serial-input signature register compacting one response bit per enabled edge.
// The next value is exported so the controller can judge pass/fail on the final edge.
module bist_sisr
    import s27_bist_pkg::*;
(
    input  logic             CK,
    input  logic             RST_N,
    input  logic             i_en,
    input  logic             i_clr,
    input  logic             i_bit,
    output logic [SIG_W-1:0] o_sig,
    output logic [SIG_W-1:0] o_sig_next_c
);

    logic [SIG_W-1:0] r_sig;
    logic             w_fb;

    assign w_fb = r_sig[SIG_W-1] ^ i_bit;

    always_comb begin
        o_sig_next_c = {r_sig[SIG_W-2:0], 1'b0} ^ (w_fb ? SISR_POLY : SIG_W'(0));
    end

    // Clear wins over enable so a restart always begins from zero
    always_ff @(posedge CK or negedge RST_N) begin
        if (!RST_N) begin
            r_sig <= '0;
        end else if (i_clr) begin
            r_sig <= '0;
        end else if (i_en) begin
            r_sig <= o_sig_next_c;
        end
    end

    assign o_sig = r_sig;

endmodule

// File: rtl/s27_bist_ctrl.sv
// BIST sequencer for the s27 core: LFSR stimulus on G0..G3, warm-up flush,
// serial compaction of G17 and a registered pass/fail verdict against GOLDEN.
module s27_bist_ctrl
    import s27_bist_pkg::*;
#(
    parameter int unsigned        WARMUP    = 3,
    parameter int unsigned        N_PAT     = 15,
    parameter logic [LFSR_W-1:0]  LFSR_SEED = 4'b0001,
    parameter logic [SIG_W-1:0]   GOLDEN    = 8'h00
) (
    input  logic             CK,
    input  logic             RST_N,
    input  logic             start,
    input  logic             G17,
    output logic             G0,
    output logic             G1,
    output logic             G2,
    output logic             G3,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [SIG_W-1:0] signature
);

    localparam logic [CNT_W-1:0] WARM_LAST = CNT_W'(WARMUP - 32'd1);
    localparam logic [CNT_W-1:0] RUN_LAST  = CNT_W'(N_PAT - 32'd1);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [LFSR_W-1:0]   r_lfsr;
    logic [LFSR_W-1:0]   w_lfsr_nxt;
    logic [CNT_W-1:0]    r_cnt;
    logic [CNT_W-1:0]    w_cnt_nxt;
    logic                r_busy;
    logic                r_done;
    logic                r_pass;
    logic                w_busy_nxt;
    logic                w_done_nxt;
    logic                w_pass_nxt;
    logic                w_sisr_en;
    logic                w_sisr_clr;
    logic [SIG_W-1:0]    w_sig;
    logic [SIG_W-1:0]    w_sig_nxt;

    bist_sisr u_sisr (
        .CK           (CK),
        .RST_N        (RST_N),
        .i_en         (w_sisr_en),
        .i_clr        (w_sisr_clr),
        .i_bit        (G17),
        .o_sig        (w_sig),
        .o_sig_next_c (w_sig_nxt)
    );

    always_ff @(posedge CK or negedge RST_N) begin
        if (!RST_N) begin
            r_state <= IDLE;
            r_lfsr  <= LFSR_SEED;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_pass  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_lfsr  <= w_lfsr_nxt;
            r_cnt   <= w_cnt_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
            r_pass  <= w_pass_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_lfsr_nxt  = r_lfsr;
        w_cnt_nxt   = r_cnt;
        w_pass_nxt  = r_pass;
        w_sisr_en   = 1'b0;
        w_sisr_clr  = 1'b0;

        case (r_state)
            IDLE, DONE: begin
                if (start) begin
                    w_lfsr_nxt  = LFSR_SEED;
                    w_cnt_nxt   = '0;
                    w_sisr_clr  = 1'b1;
                    w_pass_nxt  = 1'b0;
                    w_state_nxt = (WARMUP == 0) ? RUN : WARM;
                end
            end
            WARM: begin
                w_lfsr_nxt = lfsr_next(r_lfsr);
                if (r_cnt == WARM_LAST) begin
                    w_state_nxt = RUN;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            RUN: begin
                w_lfsr_nxt = lfsr_next(r_lfsr);
                w_sisr_en  = 1'b1;
                if (r_cnt == RUN_LAST) begin
                    // Verdict uses the signature as it will be after this edge
                    w_state_nxt = DONE;
                    w_pass_nxt  = (w_sig_nxt == GOLDEN);
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase

        w_busy_nxt = (w_state_nxt == WARM) || (w_state_nxt == RUN);
        w_done_nxt = (w_state_nxt == DONE);
    end

    // Stimulus is gated so the core sees all-zero inputs outside a test
    assign {G3, G2, G1, G0} = r_lfsr & {LFSR_W{r_busy}};
    assign busy      = r_busy;
    assign done      = r_done;
    assign pass      = r_pass;
    assign signature = w_sig;

endmodule
